// File: rtl/weight_update_unit_pkg.sv
// Shared definitions for the weight update unit.
// Holds the update-mode enum, default parameter values and a helper that sizes
// the velocity address so a single-entry memory still gets a 1-bit index.
package weight_update_unit_pkg;

    typedef enum logic {
        MODE_SGD      = 1'b0,
        MODE_MOMENTUM = 1'b1
    } mode_e;

    localparam int unsigned DefLanes = 4;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefFracW = 8;
    localparam int unsigned DefDepth = 16;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wu_lane.sv
// One weight lane of the update pipeline.
// Stage 1 (combinational into the s1 registers): reads v[addr], forms
//   v_new = Mul(beta, v) + grad and writes it back on the acceptance edge.
// Stage 2 (combinational into the output registers): W_new = W_old - Mul(lr, x),
//   where x is v_new in momentum mode and grad in SGD mode.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   accept_i            a beat is accepted this cycle (loads stage 1)
//   mode_i, beta_i      update mode and momentum coefficient of the incoming beat
//   addr_i              velocity entry index of the incoming beat
//   w_old_i, grad_i     this lane's old weight and gradient
//   clr_en_i/clr_addr_i zero one velocity entry (clear sweep)
//   s2_load_i           stage 1 advances into stage 2
//   lr_s1_i             learning rate held alongside stage 1
//   w_new_o, sat_o      registered result and saturation flag
module wu_lane
    import weight_update_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned FRAC_W = DefFracW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned AW     = addr_width(DefDepth)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept_i,
    input  mode_e             mode_i,
    input  logic [DATA_W-1:0] beta_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] w_old_i,
    input  logic [DATA_W-1:0] grad_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_addr_i,
    input  logic              s2_load_i,
    input  logic [DATA_W-1:0] lr_s1_i,
    output logic [DATA_W-1:0] w_new_o,
    output logic              sat_o
);

    localparam int unsigned PW = 2 * DATA_W;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic signed [DATA_W:0]   ext_t;
    typedef logic signed [PW-1:0]     prod_t;

    localparam word_t WordMax = {1'b0, {(DATA_W-1){1'b1}}};
    localparam word_t WordMin = {1'b1, {(DATA_W-1){1'b0}}};
    localparam prod_t ProdMax = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam prod_t ProdMin = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Full-width product, floor shift by the fraction bits, clamp to a word.
    function automatic word_t mul_sat(input word_t a, input word_t b, output logic sat);
        prod_t prod;
        prod_t shr;
        prod = prod_t'(a) * prod_t'(b);
        shr  = prod >>> FRAC_W;
        sat  = 1'b0;
        if (shr > ProdMax) begin
            sat = 1'b1;
            return WordMax;
        end
        if (shr < ProdMin) begin
            sat = 1'b1;
            return WordMin;
        end
        return word_t'(shr);
    endfunction

    // One guard bit is enough to detect overflow of a two-operand add/sub.
    function automatic word_t add_sat(input word_t a, input word_t b, input logic sub,
                                      output logic sat);
        ext_t sum;
        sum = sub ? (ext_t'(a) - ext_t'(b)) : (ext_t'(a) + ext_t'(b));
        sat = sum[DATA_W] ^ sum[DATA_W-1];
        if (sat) begin
            return sum[DATA_W] ? WordMin : WordMax;
        end
        return word_t'(sum);
    endfunction

    word_t vel_q [DEPTH];

    // Stage 1 datapath
    word_t v_old;
    word_t beta_v;
    word_t v_new;
    word_t x_s1_d;
    logic  sat_bv;
    logic  sat_vn;
    logic  sat_s1_d;

    always_comb begin
        sat_bv   = 1'b0;
        sat_vn   = 1'b0;
        v_old    = vel_q[addr_i];
        beta_v   = mul_sat(word_t'(beta_i), v_old, sat_bv);
        v_new    = add_sat(beta_v, word_t'(grad_i), 1'b0, sat_vn);
        x_s1_d   = word_t'(grad_i);
        sat_s1_d = 1'b0;
        if (mode_i == MODE_MOMENTUM) begin
            x_s1_d   = v_new;
            sat_s1_d = sat_bv | sat_vn;
        end
    end

    word_t w_s1_q;
    word_t x_s1_q;
    logic  sat_s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_s1_q   <= '0;
            x_s1_q   <= '0;
            sat_s1_q <= 1'b0;
        end else if (accept_i) begin
            w_s1_q   <= word_t'(w_old_i);
            x_s1_q   <= x_s1_d;
            sat_s1_q <= sat_s1_d;
        end
    end

    // Velocity write happens on the acceptance edge so a back-to-back beat to
    // the same entry reads the fresh value without a bypass path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                vel_q[i] <= '0;
            end
        end else if (clr_en_i) begin
            vel_q[clr_addr_i] <= '0;
        end else if (accept_i && (mode_i == MODE_MOMENTUM)) begin
            vel_q[addr_i] <= v_new;
        end
    end

    // Stage 2 datapath
    word_t lr_x;
    word_t w_new_d;
    logic  sat_lx;
    logic  sat_wn;
    logic  sat_d;

    always_comb begin
        sat_lx  = 1'b0;
        sat_wn  = 1'b0;
        lr_x    = mul_sat(word_t'(lr_s1_i), x_s1_q, sat_lx);
        w_new_d = add_sat(w_s1_q, lr_x, 1'b1, sat_wn);
        sat_d   = sat_s1_q | sat_lx | sat_wn;
    end

    word_t w_new_q;
    logic  sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_new_q <= '0;
            sat_q   <= 1'b0;
        end else if (s2_load_i) begin
            w_new_q <= w_new_d;
            sat_q   <= sat_d;
        end
    end

    assign w_new_o = w_new_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/weight_update_unit.sv
// Two-stage SGD / momentum weight update unit over LANES parallel lanes.
// The top level owns the handshake, stage valids, the learning-rate register
// for stage 1 and the velocity clear sweep; per-lane arithmetic and velocity
// storage live in wu_lane.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   mode_in, lr_in, beta_in  per-beat controls, sampled at acceptance
//   vel_clear_in             pulse that starts a velocity clear sweep
//   clear_busy_out           high while the sweep runs (DEPTH cycles)
//   in_valid/in_ready        input handshake; addr_in, w_old_in, grad_in payload
//   out_valid/out_ready      output handshake; w_new_out, sat_out payload
module weight_update_unit
    import weight_update_unit_pkg::*;
#(
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned FRAC_W = DefFracW,
    parameter int unsigned DEPTH  = DefDepth,
    localparam int unsigned AW    = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_in,
    input  logic [DATA_W-1:0]       lr_in,
    input  logic [DATA_W-1:0]       beta_in,
    input  logic                    vel_clear_in,
    output logic                    clear_busy_out,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           addr_in,
    input  logic [LANES*DATA_W-1:0] w_old_in,
    input  logic [LANES*DATA_W-1:0] grad_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] w_new_out,
    output logic [LANES-1:0]        sat_out
);

    logic              start_clear;
    logic              stall;
    logic              s2_load;
    logic              accept;
    mode_e             mode;

    logic              s1_valid_q, s1_valid_d;
    logic              out_valid_q, out_valid_d;
    logic              clear_busy_q, clear_busy_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] lr_s1_q, lr_s1_d;

    always_comb begin
        start_clear = vel_clear_in && !clear_busy_q;
        stall       = out_valid_q && !out_ready;
        s2_load     = s1_valid_q && !stall;
        // A starting clear also blocks the beat presented in the same cycle.
        in_ready    = !clear_busy_q && !start_clear && !(s1_valid_q && stall);
        accept      = in_valid && in_ready;
        mode        = mode_e'(mode_in);

        s1_valid_d  = accept || (s1_valid_q && !s2_load);
        out_valid_d = s2_load || (out_valid_q && !out_ready);
        lr_s1_d     = accept ? lr_in : lr_s1_q;

        clear_busy_d = clear_busy_q;
        clr_cnt_d    = clr_cnt_q;
        if (start_clear) begin
            clear_busy_d = 1'b1;
            clr_cnt_d    = '0;
        end else if (clear_busy_q) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                clear_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            clear_busy_q <= 1'b0;
            clr_cnt_q    <= '0;
            lr_s1_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            clear_busy_q <= clear_busy_d;
            clr_cnt_q    <= clr_cnt_d;
            lr_s1_q      <= lr_s1_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign clear_busy_out = clear_busy_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        wu_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .accept_i   (accept),
            .mode_i     (mode),
            .beta_i     (beta_in),
            .addr_i     (addr_in),
            .w_old_i    (w_old_in[g*DATA_W +: DATA_W]),
            .grad_i     (grad_in[g*DATA_W +: DATA_W]),
            .clr_en_i   (clear_busy_q),
            .clr_addr_i (clr_cnt_q),
            .s2_load_i  (s2_load),
            .lr_s1_i    (lr_s1_q),
            .w_new_o    (w_new_out[g*DATA_W +: DATA_W]),
            .sat_o      (sat_out[g])
        );
    end

endmodule
